// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage; drives a req/gnt/rvalid data-cache bus,
// aligns store data and strobes, extracts and extends load data, and stalls until done.
module stage_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_flush,
  input  logic        mem_advance,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] memaddr,
  input  logic [63:0] rs2_data,
  input  logic [63:0] alu_out,
  output logic        mem_ready,
  output logic [63:0] mem_result,
  output logic        mem_misalign,
  output logic        mem_fault,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [63:0] dbus_addr,
  output logic [63:0] dbus_wdata,
  output logic [7:0]  dbus_wstrb,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [63:0] dbus_rdata,
  input  logic        dbus_err
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, RESP = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  logic [2:0]  state, nxt, f3_q;
  logic [63:0] addr_q, wdata_q, data_q, wdata, sh, ld;
  logic [7:0]  wstrb_q, mask;
  logic        we_q, err_q, start;
  always_comb begin
    mem_misalign = mem_valid & mem_en & (funct3[1:0] == 2'd1 ? memaddr[0] :
                   funct3[1:0] == 2'd2 ? |memaddr[1:0] :
                   funct3[1:0] == 2'd3 ? |memaddr[2:0] : 1'b0);
    mask  = funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 :
            funct3[1:0] == 2'd2 ? 8'h0f : 8'hff;
    wdata = funct3[1:0] == 2'd0 ? {8{rs2_data[7:0]}} : funct3[1:0] == 2'd1 ? {4{rs2_data[15:0]}} :
            funct3[1:0] == 2'd2 ? {2{rs2_data[31:0]}} : rs2_data;
    start = state == IDLE & mem_valid & mem_en & !mem_misalign & !mem_flush;
    sh    = dbus_rdata >> {addr_q[2:0], 3'b000};
    ld    = f3_q[1:0] == 2'd0 ? {{56{sh[7] & !f3_q[2]}}, sh[7:0]} :
            f3_q[1:0] == 2'd1 ? {{48{sh[15] & !f3_q[2]}}, sh[15:0]} :
            f3_q[1:0] == 2'd2 ? {{32{sh[31] & !f3_q[2]}}, sh[31:0]} : sh;
    nxt = state;
    case (state)
      IDLE:    nxt = start ? REQ : IDLE;
      // a grant coinciding with a flush still leaves a response in flight
      REQ:     nxt = dbus_gnt ? (mem_flush ? DRAIN : RESP) : (mem_flush ? IDLE : REQ);
      RESP:    nxt = mem_flush ? (dbus_rvalid ? IDLE : DRAIN) : (dbus_rvalid ? DONE : RESP);
      DRAIN:   nxt = dbus_rvalid ? IDLE : DRAIN;
      DONE:    nxt = (mem_advance | mem_flush) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        addr_q  <= memaddr;
        wdata_q <= wdata;
        wstrb_q <= mem_write ? mask << memaddr[2:0] : 8'h00;
        f3_q    <= funct3;
        we_q    <= mem_write;
      end
      if (state == RESP & dbus_rvalid & !mem_flush) begin
        data_q <= ld;
        err_q  <= dbus_err;
      end
    end
  end
  assign dbus_req   = state == REQ;
  assign dbus_we    = we_q;
  assign dbus_addr  = {addr_q[63:3], 3'b000};
  assign dbus_wdata = wdata_q;
  assign dbus_wstrb = wstrb_q;
  assign mem_ready  = state == DONE | (state == IDLE & (!mem_valid | !mem_en | mem_misalign | mem_flush));
  assign mem_result = !mem_en ? alu_out : (state == DONE & !we_q) ? data_q : 64'd0;
  assign mem_fault  = state == DONE & err_q;
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed vector table plus hand-written bus transaction sequences.
module tb_stage_mem;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_valid = 0, mem_flush = 0, mem_advance = 0, mem_en = 0, mem_write = 0;
  logic [2:0]  funct3 = 0;
  logic [63:0] memaddr = 0, rs2_data = 0, alu_out = 0;
  logic        mem_ready, mem_misalign, mem_fault, dbus_req, dbus_we;
  logic [63:0] mem_result, dbus_addr, dbus_wdata;
  logic [7:0]  dbus_wstrb;
  logic        dbus_gnt = 0, dbus_rvalid = 0, dbus_err = 0;
  logic [63:0] dbus_rdata = 0;
  int nvec = 0, nerr = 0;

  stage_mem dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_flush(mem_flush), .mem_advance(mem_advance),
    .mem_en(mem_en), .mem_write(mem_write), .funct3(funct3), .memaddr(memaddr), .rs2_data(rs2_data),
    .alu_out(alu_out), .mem_ready(mem_ready), .mem_result(mem_result), .mem_misalign(mem_misalign),
    .mem_fault(mem_fault), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .dbus_err(dbus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, en, we, flush;
    logic [2:0]  f3;
    logic [63:0] addr, alu;
    logic        exp_ready, exp_mis;
    logic [63:0] exp_res;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic w, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] d);
    mem_valid = v; mem_en = e; mem_write = w; funct3 = f; memaddr = a; rs2_data = d;
  endtask

  task automatic access(input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d,
                        input int gw, input logic [63:0] rdata, input logic err,
                        input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                        input logic [63:0] exp_res, input logic exp_fault);
    @(negedge clk);
    drive(1, 1, w, f, a, d);
    #1 chk("start_ready", mem_ready, 0);
    for (int k = 0; k <= gw; k++) begin
      @(negedge clk);
      #1 chk("req", dbus_req, 1);
      chk("addr", dbus_addr, a & ~64'h7);
      chk("we", dbus_we, w);
      chk("wstrb", dbus_wstrb, exp_strb);
      if (w) chk("wdata", dbus_wdata, exp_wdata);
      chk("req_ready", mem_ready, 0);
      dbus_gnt = (k == gw);
    end
    @(negedge clk);
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = rdata; dbus_err = err;
    #1 chk("resp_req", dbus_req, 0);
    chk("resp_ready", mem_ready, 0);
    @(negedge clk);
    dbus_rvalid = 0; dbus_err = 0;
    #1 chk("done_ready", mem_ready, 1);
    chk("done_result", mem_result, exp_res);
    chk("done_fault", mem_fault, exp_fault);
    @(negedge clk);
    #1 chk("hold_ready", mem_ready, 1);
    chk("hold_fault", mem_fault, exp_fault);
    mem_advance = 1;
    @(negedge clk);
    mem_advance = 0;
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("after_fault", mem_fault, 0);
    chk("after_req", dbus_req, 0);
  endtask

  initial begin
    //          valid en we flush f3  addr         alu       ready mis result
    tbl[0] = '{1, 0, 0, 0, 3'd0, 64'h0,      64'h1234, 1, 0, 64'h1234};
    tbl[1] = '{0, 1, 0, 0, 3'd2, 64'h3002,   64'h55,   1, 0, 64'h0};
    tbl[2] = '{1, 1, 0, 0, 3'd2, 64'h3002,   64'h55,   1, 1, 64'h0};
    tbl[3] = '{1, 1, 0, 0, 3'd1, 64'h3001,   64'h55,   1, 1, 64'h0};
    tbl[4] = '{1, 1, 1, 0, 3'd3, 64'h3004,   64'h55,   1, 1, 64'h0};
    tbl[5] = '{1, 1, 0, 0, 3'd0, 64'h3007,   64'h55,   0, 0, 64'h0};
    tbl[6] = '{1, 1, 0, 0, 3'd5, 64'h3002,   64'h55,   0, 0, 64'h0};
    tbl[7] = '{1, 1, 0, 1, 3'd2, 64'h3000,   64'h55,   1, 0, 64'h0};
    tbl[8] = '{1, 1, 1, 0, 3'd3, 64'h3008,   64'h55,   0, 0, 64'h0};
    tbl[9] = '{1, 1, 0, 0, 3'd6, 64'h3006,   64'h55,   1, 1, 64'h0};

    #1 chk("rst_req", dbus_req, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_ready", mem_ready, 1);
    repeat (2) @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].en, tbl[i].we, tbl[i].f3, tbl[i].addr, 64'h0);
      mem_flush = tbl[i].flush; alu_out = tbl[i].alu;
      #1 chk($sformatf("v%0d_ready", i), mem_ready, tbl[i].exp_ready);
      chk($sformatf("v%0d_mis", i), mem_misalign, tbl[i].exp_mis);
      chk($sformatf("v%0d_result", i), mem_result, tbl[i].exp_res);
      chk($sformatf("v%0d_req", i), dbus_req, 0);
      #1 drive(0, 0, 0, 0, 0, 0);
      mem_flush = 0;
    end

    @(negedge clk);
    drive(1, 1, 0, 3'd2, 64'h3002, 0);
    repeat (3) begin
      #1 chk("mis_req", dbus_req, 0);
      chk("mis_ready", mem_ready, 1);
      chk("mis_flag", mem_misalign, 1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);

    access(0, 3'd0, 64'h1003, 0, 0, 64'h00000000_80000000, 0, 8'h00, 0, 64'hFFFFFFFF_FFFFFF80, 0);
    access(0, 3'd4, 64'h1003, 0, 0, 64'h00000000_80000000, 0, 8'h00, 0, 64'h80, 0);
    access(1, 3'd1, 64'h2006, 64'hABCD, 0, 64'h0, 0, 8'hC0, 64'hABCDABCD_ABCDABCD, 64'h0, 0);
    access(1, 3'd2, 64'h1004, 64'h11223344, 1, 64'h0, 0, 8'hF0, 64'h11223344_11223344, 64'h0, 0);
    access(0, 3'd2, 64'h0010, 0, 0, 64'h00000000_87654321, 0, 8'h00, 0, 64'hFFFFFFFF_87654321, 0);
    access(0, 3'd5, 64'h0022, 0, 2, 64'h00000000_F00D0000, 0, 8'h00, 0, 64'hF00D, 0);
    access(0, 3'd3, 64'h0018, 0, 3, 64'hDEADBEEF_CAFEF00D, 1, 8'h00, 0, 64'hDEADBEEF_CAFEF00D, 1);
    access(1, 3'd0, 64'h0105, 64'h7E, 0, 64'h0, 1, 8'h20, 64'h7E7E7E7E_7E7E7E7E, 64'h0, 1);

    // flush while waiting for the response: late rvalid discarded
    @(negedge clk);
    drive(1, 1, 0, 3'd3, 64'h4000, 0);
    @(negedge clk);
    dbus_gnt = 1;
    @(negedge clk);
    dbus_gnt = 0; mem_flush = 1;
    #1 chk("flush_resp_ready", mem_ready, 0);
    @(negedge clk);
    mem_flush = 0; drive(0, 0, 0, 0, 0, 0);
    #1 chk("drain_ready", mem_ready, 0);
    chk("drain_req", dbus_req, 0);
    dbus_rvalid = 1; dbus_err = 1; dbus_rdata = 64'h1;
    @(negedge clk);
    dbus_rvalid = 0; dbus_err = 0;
    #1 chk("drain_idle_ready", mem_ready, 1);
    chk("drain_fault", mem_fault, 0);
    chk("drain_idle_req", dbus_req, 0);

    // flush before grant: request withdrawn next cycle
    @(negedge clk);
    drive(1, 1, 0, 3'd3, 64'h4008, 0);
    @(negedge clk);
    #1 chk("freq_req", dbus_req, 1);
    mem_flush = 1;
    @(negedge clk);
    mem_flush = 0; drive(0, 0, 0, 0, 0, 0);
    #1 chk("freq_drop", dbus_req, 0);
    chk("freq_ready", mem_ready, 1);

    // asynchronous reset while requesting
    @(negedge clk);
    drive(1, 1, 0, 3'd3, 64'h5000, 0);
    @(negedge clk);
    #1 chk("arst_req_before", dbus_req, 1);
    #2 rst = 1;
    #1 chk("arst_req_async", dbus_req, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 0;
    @(negedge clk);
    #1 chk("arst_req_after", dbus_req, 0);
    chk("arst_ready", mem_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
